// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and helpers.
// Holds the default 640x480@60 timing (porches, sync widths, totals), the
// visible extents reused by the graphics modules (MAX_X/MAX_Y), the refresh
// line on which the frame strobe fires, and the counter width.
package vga_timing_pkg;

    localparam int CNT_W     = 10;

    localparam int H_DISP    = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOT     = H_DISP + H_FP + H_SYNC + H_BP;

    localparam int V_DISP    = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOT     = V_DISP + V_FP + V_SYNC + V_BP;

    localparam int MAX_X     = H_DISP;
    localparam int MAX_Y     = V_DISP;
    localparam int TICK_LINE = 481;

    // True when pos lies in [start, start+width-1].
    function automatic logic in_window(input logic [CNT_W-1:0] pos,
                                       input int start, input int width);
        return (int'(pos) >= start) && (int'(pos) < start + width);
    endfunction

endpackage

// File: rtl/mod_m_counter.sv
// Modulo-M counter with enable.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset (count -> 0)
//   en_i         : advance by one this clk
//   cnt_o        : current count, 0..M-1
//   next_o       : value the count takes after this clk edge
//   wrap_o       : high in the enabled clk where the count goes M-1 -> 0
module mod_m_counter #(
    parameter int M = 10,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic [W-1:0] next_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] LAST = W'(M - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign wrap_o = en_i && (cnt_q == LAST);

    always_comb begin
        // NOTE: default first so every path assigns cnt_d; no latch is inferred.
        cnt_d = cnt_q;
        if (wrap_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            // NOTE: non-blocking so all registers update together at the edge.
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign next_o = cnt_d;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator.
// A clock divider produces the pixel strobe; two cascaded counters walk the
// raster. Syncs and the colour output are registered so they line up with
// the pixel counters the DAC sees.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   rgb_in         : colour for the current pix_x/pix_y
//   p_tick         : pixel-enable strobe (one clk every DIV clks)
//   pix_x, pix_y   : raster position
//   video_on       : position is inside the visible area
//   hsync, vsync   : active-low syncs, registered
//   frame_tick     : one-clk strobe at (0, TICK_LINE)
//   frame_cnt      : frames seen, modulo 256
//   rgb_out        : registered colour, black during blanking
module vga_sync_gen #(
    parameter int DIV       = 4,
    parameter int H_DISP    = vga_timing_pkg::H_DISP,
    parameter int H_FP      = vga_timing_pkg::H_FP,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BP      = vga_timing_pkg::H_BP,
    parameter int V_DISP    = vga_timing_pkg::V_DISP,
    parameter int V_FP      = vga_timing_pkg::V_FP,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BP      = vga_timing_pkg::V_BP,
    parameter int TICK_LINE = vga_timing_pkg::TICK_LINE
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [11:0]                       rgb_in,
    output logic                              p_tick,
    output logic [vga_timing_pkg::CNT_W-1:0]  pix_x,
    output logic [vga_timing_pkg::CNT_W-1:0]  pix_y,
    output logic                              video_on,
    output logic                              hsync,
    output logic                              vsync,
    output logic                              frame_tick,
    output logic [7:0]                        frame_cnt,
    output logic [11:0]                       rgb_out
);

    import vga_timing_pkg::*;

    localparam int H_TOTAL      = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_DISP + H_FP;
    localparam int V_SYNC_START = V_DISP + V_FP;

    if (DIV < 1 || DIV > 16) begin : g_bad_div
        $error("vga_sync_gen: DIV must be in 1..16");
    end
    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_tot
        $error("vga_sync_gen: H_TOT and V_TOT must not exceed 1024");
    end

    logic [3:0]       div_cnt;
    logic [3:0]       div_next;
    logic [CNT_W-1:0] x_next;
    logic [CNT_W-1:0] y_next;
    logic             x_wrap;
    logic             y_wrap;

    mod_m_counter #(.M(DIV), .W(4)) u_div (
        .clk    (clk),
        .reset_n(reset_n),
        .en_i   (1'b1),
        .cnt_o  (div_cnt),
        .next_o (div_next),
        .wrap_o (p_tick)
    );

    mod_m_counter #(.M(H_TOTAL), .W(CNT_W)) u_hcnt (
        .clk    (clk),
        .reset_n(reset_n),
        .en_i   (p_tick),
        .cnt_o  (pix_x),
        .next_o (x_next),
        .wrap_o (x_wrap)
    );

    mod_m_counter #(.M(V_TOTAL), .W(CNT_W)) u_vcnt (
        .clk    (clk),
        .reset_n(reset_n),
        .en_i   (x_wrap),
        .cnt_o  (pix_y),
        .next_o (y_next),
        .wrap_o (y_wrap)
    );

    // Only the strobe is needed from the divider, and the frame end is
    // detected from pix_y directly.
    logic unused_cnt;
    assign unused_cnt = ^{div_cnt, div_next, y_wrap};

    assign video_on = (int'(pix_x) < H_DISP) && (int'(pix_y) < V_DISP);

    // Gated by reset_n so the strobe stays low in reset even when
    // TICK_LINE is 0 and DIV is 1.
    assign frame_tick = reset_n && p_tick && (pix_x == '0)
                        && (int'(pix_y) == TICK_LINE);

    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic [11:0] rgb_q, rgb_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;

    // Syncs are decoded from the counters' next values so the registered
    // result lands in the same clk as the position it belongs to.
    always_comb begin
        hsync_d     = !in_window(x_next, H_SYNC_START, H_SYNC);
        vsync_d     = !in_window(y_next, V_SYNC_START, V_SYNC);
        rgb_d       = rgb_q;
        frame_cnt_d = frame_cnt_q + {7'd0, frame_tick};
        if (p_tick) begin
            rgb_d = video_on ? rgb_in : 12'h000;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            rgb_q       <= 12'h000;
            frame_cnt_q <= 8'd0;
        end else begin
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            rgb_q       <= rgb_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign rgb_out   = rgb_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen using a shrunken raster (15 x 10 totals) so that
// whole frames, the 256-frame counter wrap and a mid-frame reset fit in a
// short run. dut_a runs with DIV=3, dut_b with DIV=1.
module tb_vga_sync_gen;

    localparam int HD = 8, HF = 2, HS = 3, HB = 2;
    localparam int VD = 6, VF = 1, VS = 2, VB = 1;
    localparam int TL = 7;
    localparam int HT = HD + HF + HS + HB;   // 15
    localparam int VT = VD + VF + VS + VB;   // 10
    localparam int FR = HT * VT;             // pixels per frame
    localparam int P0 = TL * HT;             // pixel index of the frame strobe
    localparam int DIV_A = 3;
    localparam int DIV_B = 1;
    localparam int N_CYC = 38420;

    typedef struct packed {
        logic        p_tick;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        vo;
        logic        hs;
        logic        vs;
        logic        ft;
        logic [7:0]  fc;
        logic [11:0] rgb;
    } obs_t;

    typedef struct {
        int         n;
        logic [9:0] x;
        logic [9:0] y;
        logic       p, hs, vs, vo, ft;
        logic [7:0] fc;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a_n, rst_b_n;
    logic [11:0] rgb_a, rgb_b;
    logic        p_a, p_b, vo_a, vo_b, hs_a, hs_b, vs_a, vs_b, ft_a, ft_b;
    logic [9:0]  x_a, x_b, y_a, y_b;
    logic [7:0]  fc_a, fc_b;
    logic [11:0] ro_a, ro_b;

    vga_sync_gen #(.DIV(DIV_A), .H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .TICK_LINE(TL)) dut_a (
        .clk(clk), .reset_n(rst_a_n), .rgb_in(rgb_a), .p_tick(p_a), .pix_x(x_a),
        .pix_y(y_a), .video_on(vo_a), .hsync(hs_a), .vsync(vs_a),
        .frame_tick(ft_a), .frame_cnt(fc_a), .rgb_out(ro_a));

    vga_sync_gen #(.DIV(DIV_B), .H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .TICK_LINE(TL)) dut_b (
        .clk(clk), .reset_n(rst_b_n), .rgb_in(rgb_b), .p_tick(p_b), .pix_x(x_b),
        .pix_y(y_b), .video_on(vo_b), .hsync(hs_b), .vsync(vs_b),
        .frame_tick(ft_b), .frame_cnt(fc_b), .rgb_out(ro_b));

    obs_t obs_a, obs_b;
    assign obs_a = {p_a, x_a, y_a, vo_a, hs_a, vs_a, ft_a, fc_a, ro_a};
    assign obs_b = {p_b, x_b, y_b, vo_b, hs_b, vs_b, ft_b, fc_b, ro_b};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: position follows from the number of clks since release by
    // plain division; frame_cnt counts strobes at pixels P0 + k*FR that have
    // already completed. Colour is tracked by the caller.
    function automatic obs_t model(input int div, input int n, input logic [11:0] rgb);
        obs_t o;
        int pix, x, y, ticks;
        pix   = n / div;
        x     = pix % HT;
        y     = (pix / HT) % VT;
        ticks = (pix > P0) ? (pix - P0 - 1) / FR + 1 : 0;
        o.p_tick = ((n % div) == div - 1);
        o.x   = 10'(x);
        o.y   = 10'(y);
        o.vo  = (x < HD) && (y < VD);
        o.hs  = !((x >= HD + HF) && (x < HD + HF + HS));
        o.vs  = !((y >= VD + VF) && (y < VD + VF + VS));
        o.ft  = o.p_tick && (x == 0) && (y == TL);
        o.fc  = 8'(ticks % 256);
        o.rgb = rgb;
        return o;
    endfunction

    function automatic vec_t mk(input int n, input int x, input int y, input bit p,
                                input bit hs, input bit vs, input bit vo, input bit ft,
                                input int fc);
        vec_t v;
        v.n = n; v.x = 10'(x); v.y = 10'(y); v.p = p; v.hs = hs; v.vs = vs;
        v.vo = vo; v.ft = ft; v.fc = 8'(fc);
        return v;
    endfunction

    // Reset values: x, y, hsync, vsync, frame_tick, frame_cnt, rgb_out.
    localparam logic [42:0] RST_EXP = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 8'd0, 12'h000};

    initial begin
        vec_t        tab[$];
        int          na, nb, ti, phase, hold;
        logic [11:0] exp_rgb_a, exp_rgb_b;
        obs_t        ma, mb;

        // Hand-derived checkpoints for dut_a (DIV=3), in clks since release.
        tab.push_back(mk(  0,  0, 0, 0, 1, 1, 1, 0, 0));
        tab.push_back(mk(  2,  0, 0, 1, 1, 1, 1, 0, 0));
        tab.push_back(mk(  3,  1, 0, 0, 1, 1, 1, 0, 0));
        tab.push_back(mk( 24,  8, 0, 0, 1, 1, 0, 0, 0));
        tab.push_back(mk( 30, 10, 0, 0, 0, 1, 0, 0, 0));
        tab.push_back(mk( 38, 12, 0, 1, 0, 1, 0, 0, 0));
        tab.push_back(mk( 39, 13, 0, 0, 1, 1, 0, 0, 0));
        tab.push_back(mk( 44, 14, 0, 1, 1, 1, 0, 0, 0));
        tab.push_back(mk( 45,  0, 1, 0, 1, 1, 1, 0, 0));
        tab.push_back(mk( 90,  0, 2, 0, 1, 1, 1, 0, 0));
        tab.push_back(mk(270,  0, 6, 0, 1, 1, 0, 0, 0));
        tab.push_back(mk(315,  0, 7, 0, 1, 0, 0, 0, 0));
        tab.push_back(mk(317,  0, 7, 1, 1, 0, 0, 1, 0));
        tab.push_back(mk(318,  1, 7, 0, 1, 0, 0, 0, 1));
        tab.push_back(mk(360,  0, 8, 0, 1, 0, 0, 0, 1));
        tab.push_back(mk(405,  0, 9, 0, 1, 1, 0, 0, 1));
        tab.push_back(mk(449, 14, 9, 1, 1, 1, 0, 0, 1));
        tab.push_back(mk(450,  0, 0, 0, 1, 1, 1, 0, 1));
        tab.push_back(mk(799, 11, 7, 0, 0, 0, 0, 0, 2));

        rst_a_n = 1'b0; rst_b_n = 1'b0;
        rgb_a = 12'hf00; rgb_b = 12'hf00;
        na = 0; nb = 0; ti = 0; phase = 0; hold = 0;
        exp_rgb_a = 12'h000; exp_rgb_b = 12'h000;

        repeat (3) @(negedge clk);
        check("reset_a", 64'({x_a, y_a, hs_a, vs_a, ft_a, fc_a, ro_a}), 64'(RST_EXP));
        check("reset_b", 64'({x_b, y_b, hs_b, vs_b, ft_b, fc_b, ro_b}), 64'(RST_EXP));
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            if (cyc > 0) @(negedge clk);

            // ---------------- dut_a ----------------
            if (phase == 1) begin
                check($sformatf("a_reset_hold %0d", hold),
                      64'({p_a, x_a, y_a, hs_a, vs_a, ft_a, fc_a, ro_a}), 64'({1'b0, RST_EXP}));
                hold++;
                if (hold == 2) begin
                    rst_a_n   = 1'b1;
                    na        = 0;
                    exp_rgb_a = 12'h000;
                    phase     = 2;
                end
            end
            if (phase != 1) begin
                ma = model(DIV_A, na, exp_rgb_a);
                check($sformatf("a_cycle n=%0d ph=%0d", na, phase), 64'(obs_a), 64'(ma));
                if (phase == 0 && ti < tab.size() && tab[ti].n == na) begin
                    check($sformatf("a_table n=%0d", na),
                          64'({p_a, x_a, y_a, hs_a, vs_a, vo_a, ft_a, fc_a}),
                          64'({tab[ti].p, tab[ti].x, tab[ti].y, tab[ti].hs, tab[ti].vs,
                               tab[ti].vo, tab[ti].ft, tab[ti].fc}));
                    ti++;
                end
                if (phase == 2 && na == 2)
                    check("a_restart_first_ptick", 64'({p_a, x_a, y_a}), 64'({1'b1, 10'd0, 10'd0}));
                if (phase == 2 && na == 3)
                    check("a_restart_x1", 64'({p_a, x_a, y_a}), 64'({1'b0, 10'd1, 10'd0}));

                if (phase == 0 && na == 799) begin
                    // Mid-pixel at (11,7), both syncs low, frame_cnt 2.
                    #1 rst_a_n = 1'b0;
                    #1 check("a_reset_async",
                             64'({p_a, x_a, y_a, hs_a, vs_a, ft_a, fc_a, ro_a}),
                             64'({1'b0, RST_EXP}));
                    phase = 1;
                    hold  = 0;
                end else begin
                    rgb_a = 12'($urandom);
                    if (ma.p_tick) exp_rgb_a = ma.vo ? rgb_a : 12'h000;
                    na++;
                end
            end

            // ---------------- dut_b ----------------
            mb = model(DIV_B, nb, exp_rgb_b);
            check($sformatf("b_cycle n=%0d", nb), 64'(obs_b), 64'(mb));
            if (nb == 0 || nb == 7)
                check($sformatf("b_ptick_const n=%0d", nb), 64'(p_b), 64'(1'b1));
            if (nb == FR)
                check("b_frame_wrap", 64'({x_b, y_b, fc_b}), 64'({10'd0, 10'd0, 8'd1}));
            if (nb == P0 + 255 * FR)
                check("b_fc_255", 64'({ft_b, fc_b}), 64'({1'b1, 8'd255}));
            if (nb == P0 + 255 * FR + 1)
                check("b_fc_wrap0", 64'({ft_b, fc_b}), 64'({1'b0, 8'd0}));
            rgb_b = 12'($urandom);
            if (mb.p_tick) exp_rgb_b = mb.vo ? rgb_b : 12'h000;
            nb++;
        end

        if (ti != tab.size()) begin
            n_cmp++;
            n_bad++;
            $display("FAIL a_table_coverage: reached %0d of %0d entries", ti, tab.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
